// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the fetch requester, memory-stage requester and
// dmem port signals seen by dmem_arbiter.
//   master : arbiter side (drives grants, read returns and dmem strobes)
//   slave  : environment side (requesters and data memory)
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rd_valid;
  logic [DATA_W-1:0] if_rd_data;
  // Memory-stage requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wr_data;
  logic [1:0]        dm_wr_size;
  logic              dm_gnt;
  logic              dm_rd_valid;
  logic [DATA_W-1:0] dm_rd_data;
  // Data memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_enable;
  logic [1:0]        mem_wr_size;
  logic              mem_rd_enable;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_ready;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rd_valid, if_rd_data,
    input  dm_req, dm_we, dm_addr, dm_wr_data, dm_wr_size,
    output dm_gnt, dm_rd_valid, dm_rd_data,
    output mem_addr, mem_wr_data, mem_wr_enable, mem_wr_size, mem_rd_enable,
    input  mem_rd_data, mem_rd_ready
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rd_valid, if_rd_data,
    output dm_req, dm_we, dm_addr, dm_wr_data, dm_wr_size,
    input  dm_gnt, dm_rd_valid, dm_rd_data,
    input  mem_addr, mem_wr_data, mem_wr_enable, mem_wr_size, mem_rd_enable,
    output mem_rd_data, mem_rd_ready
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between instruction fetch
// (reads only) and the memory stage (loads and stores). One registered grant
// per access; read strobes are held until mem_rd_ready.
// Optional macro ARB_FAIR_EN: after STARVE_LIMIT consecutive dm grants made
// while fetch is waiting, the next arbitration point goes to fetch.
// Requesters are expected to drop or replace their request in the cycle the
// grant pulse is visible, otherwise the held request is accepted again.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  dmem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_DM, WR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_arb;
  logic              w_rd_done;
  logic              w_gnt_if;
  logic              w_gnt_dm;
  logic              w_starved;

  logic              r_if_gnt;
  logic              r_dm_gnt;
  logic              r_if_rd_valid;
  logic              r_dm_rd_valid;
  logic [DATA_W-1:0] r_if_rd_data;
  logic [DATA_W-1:0] r_dm_rd_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;
  logic [1:0]        r_mem_wr_size;
  logic              r_mem_wr_enable;
  logic              r_mem_rd_enable;
  logic              r_flush_kill;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Arbitration and next-state: decide only when the port is free or the read completes
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_if    = 1'b0;
    w_gnt_dm    = 1'b0;
    w_rd_done   = ((r_state == RD_IF) || (r_state == RD_DM)) && bus.mem_rd_ready;
    w_arb       = (r_state == IDLE) || (r_state == WR) || w_rd_done;
    if (w_arb) begin
      if (bus.if_req && (w_starved || !bus.dm_req)) begin
        w_gnt_if    = 1'b1;
        w_state_nxt = RD_IF;
      end else if (bus.dm_req) begin
        w_gnt_dm    = 1'b1;
        w_state_nxt = bus.dm_we ? WR : RD_DM;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

`ifdef ARB_FAIR_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] r_starve;

  // Count dm wins over a waiting fetch; saturates at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_starve <= '0;
    else if (!bus.if_req || w_gnt_if)
      r_starve <= '0;
    else if (w_gnt_dm && (r_starve != STARVE_W'(STARVE_LIMIT)))
      r_starve <= r_starve + 1'b1;
  end

  assign w_starved = (r_starve == STARVE_W'(STARVE_LIMIT));
`else
  assign w_starved = 1'b0;
`endif

  // Flush kill: remembers a flush seen during an outstanding dm load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_flush_kill <= 1'b0;
    else if ((r_state == RD_DM) && !bus.mem_rd_ready)
      r_flush_kill <= r_flush_kill | flush;
    else
      r_flush_kill <= 1'b0;
  end

  // Grant pulses, read returns and dmem strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_gnt        <= 1'b0;
      r_dm_gnt        <= 1'b0;
      r_if_rd_valid   <= 1'b0;
      r_dm_rd_valid   <= 1'b0;
      r_if_rd_data    <= '0;
      r_dm_rd_data    <= '0;
      r_mem_addr      <= '0;
      r_mem_wr_data   <= '0;
      r_mem_wr_size   <= '0;
      r_mem_wr_enable <= 1'b0;
      r_mem_rd_enable <= 1'b0;
    end else begin
      r_if_gnt        <= w_gnt_if;
      r_dm_gnt        <= w_gnt_dm;
      r_if_rd_valid   <= w_rd_done && (r_state == RD_IF);
      r_dm_rd_valid   <= w_rd_done && (r_state == RD_DM) && !flush && !r_flush_kill;
      r_mem_wr_enable <= w_gnt_dm && bus.dm_we;

      if (w_rd_done && (r_state == RD_IF)) r_if_rd_data <= bus.mem_rd_data;
      if (w_rd_done && (r_state == RD_DM)) r_dm_rd_data <= bus.mem_rd_data;

      if (w_gnt_if) begin
        r_mem_addr      <= bus.if_addr;
        r_mem_rd_enable <= 1'b1;
      end else if (w_gnt_dm) begin
        r_mem_addr      <= bus.dm_addr;
        r_mem_rd_enable <= !bus.dm_we;
        if (bus.dm_we) begin
          r_mem_wr_data <= bus.dm_wr_data;
          r_mem_wr_size <= bus.dm_wr_size;
        end
      end else if (w_arb) begin
        r_mem_rd_enable <= 1'b0;
      end
    end
  end

  assign bus.if_gnt        = r_if_gnt;
  assign bus.dm_gnt        = r_dm_gnt;
  assign bus.if_rd_valid   = r_if_rd_valid;
  assign bus.dm_rd_valid   = r_dm_rd_valid;
  assign bus.if_rd_data    = r_if_rd_data;
  assign bus.dm_rd_data    = r_dm_rd_data;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wr_data   = r_mem_wr_data;
  assign bus.mem_wr_size   = r_mem_wr_size;
  assign bus.mem_wr_enable = r_mem_wr_enable;
  assign bus.mem_rd_enable = r_mem_rd_enable;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port between the instruction-fetch stage (read-only) and the memory stage (loads and stores). It sits between the pipeline stages and the dmem interface and owns `mem_addr`, `mem_wr_*` and `mem_rd_enable`. It sequences each access as one registered grant, holds read strobes until `mem_rd_ready`, and returns read data to the winning requester.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive dm grants with `if_req` pending before fetch is forced to win (used only with `ARB_FAIR_EN`)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `flush`  in  1  pipeline flush; suppresses pending dm read return
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  one-cycle accept pulse
- `if_rd_valid`  out  1  one-cycle read-return pulse
- `if_rd_data`  out  DATA_W  fetch read data, valid with `if_rd_valid`
- `dm_req`  in  1  memory-stage request; held with fields stable until `dm_gnt`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  load/store address
- `dm_wr_data`  in  DATA_W  store data
- `dm_wr_size`  in  2  store size (00 byte, 01 half, 10 word)
- `dm_gnt`  out  1  one-cycle accept pulse
- `dm_rd_valid`  out  1  one-cycle load-return pulse
- `dm_rd_data`  out  DATA_W  raw load data (sign/zero extension done by the memory stage)
- `mem_addr`  out  ADDR_W  dmem address
- `mem_wr_data`  out  DATA_W  dmem write data
- `mem_wr_enable`  out  1  dmem write strobe
- `mem_wr_size`  out  2  dmem write size
- `mem_rd_enable`  out  1  dmem read strobe, held until ready
- `mem_rd_data`  in  DATA_W  dmem read data
- `mem_rd_ready`  in  1  dmem read complete; `mem_rd_data` valid

## Operation
- States: IDLE, RD_IF, RD_DM, WR.
- Arbitration points: state IDLE, state WR, or state RD_* with `mem_rd_ready`=1. No arbitration elsewhere.
- Priority: `dm_req` beats `if_req` (older instruction), except under `ARB_FAIR_EN` starvation rule.
- Grant to fetch: `if_gnt`=1, `mem_addr`<=`if_addr`, `mem_rd_enable`<=1, go RD_IF.
- Grant to dm load: `dm_gnt`=1, `mem_addr`<=`dm_addr`, `mem_rd_enable`<=1, go RD_DM.
- Grant to dm store: `dm_gnt`=1, `mem_addr`/`mem_wr_data`/`mem_wr_size` loaded, `mem_wr_enable`<=1 for exactly one cycle, go WR. Stores need no ready.
- RD_*: `mem_rd_enable` and `mem_addr` held. On `mem_rd_ready`, capture `mem_rd_data` into the owner's `*_rd_data`, pulse `*_rd_valid` next cycle, deassert `mem_rd_enable` unless the same edge grants a new read.
- No request at an arbitration point: go IDLE, all strobes 0.
- Flush: if asserted while in RD_DM, or sampled at the completing edge, the memory read still completes, but `dm_rd_valid` is suppressed. Fetch traffic is unaffected. A flush in IDLE/WR clears nothing else. Requesters drop `dm_req` themselves.

## Timing
- Reset: all outputs 0, state IDLE, starve counter 0, flush-kill flag 0. An assertion mid-read abandons the transaction; `mem_rd_enable` drops immediately.
- Grant latency: request seen at edge N → `*_gnt` and memory strobes valid in cycle N+1.
- Read latency: `mem_rd_ready` seen at edge M → `*_rd_valid` in cycle M+1.
- Back-to-back reads: new grant may coincide with the previous `*_rd_valid` cycle. Zero-wait memory gives 1 access per cycle after the first.
- `*_gnt` and `*_rd_valid` are never asserted for both requesters in the same cycle.
- `mem_rd_enable` and `mem_wr_enable` are never high together.
- `mem_rd_ready` outside RD_* is ignored.

## Configuration
- `ARB_FAIR_EN` defined: a saturating counter increments on each dm grant made while `if_req`=1. It clears on any if grant or when `if_req`=0. When counter==`STARVE_LIMIT`, the next arbitration point grants fetch even if `dm_req`=1.
- Undefined: strict dm priority, no counter logic. `STARVE_LIMIT` is ignored.

## Test plan
- Fetch-only read, `if_addr`=0x100, ready 2 cycles after `mem_rd_enable`, data 0xDEADBEEF → `if_gnt` in cycle 1, `if_rd_valid`=1 with 0xDEADBEEF exactly one cycle after ready.
- Simultaneous `if_req` and `dm_req` load at 0x200 → `dm_gnt` first, `mem_addr`=0x200, fetch granted at the completing edge.
- Store 0x12345678 size 10 to 0x40 → `mem_wr_enable` high for exactly one cycle with matching addr/data/size, state returns IDLE, no `dm_rd_valid`.
- Load in flight with `flush` pulsed one cycle before ready → `mem_rd_enable` held until ready, `dm_rd_valid` never asserted.
- `ARB_FAIR_EN`, `STARVE_LIMIT`=4, `dm_req` and `if_req` both constantly high, zero-wait memory → 4 dm grants, then 1 if grant, repeating. Without the macro: no if grant.
- `reset` driven low during RD_IF → `mem_rd_enable`, `if_gnt`, `if_rd_valid` go 0 asynchronously; after release, the first request is granted normally.
